// File: rtl/aha_reset_sequencer.sv
// aha_reset_sequencer
// Purpose: issues software reset requests to NUM_TARGETS reset generators one
// at a time, lowest index first. Each target gets a 4-phase REQ/ACK handshake.
// Each handshake phase has a timeout, and an idle gap separates consecutive
// targets.
// Ports:
//   i_clk        SYS_FCLK system clock
//   i_rst        asynchronous active-high reset
//   i_seq_start  start pulse, honoured only when idle
//   i_seq_mask   targets to reset, sampled together with i_seq_start
//   i_seq_abort  stop after the current target's handshake completes
//   o_rst_req    one-hot (or zero) request to the reset generators
//   i_rst_ack    acknowledges from the generators, asynchronous to i_clk
//   o_busy       high whenever a sequence is active
//   o_done       one-cycle pulse at sequence end
//   o_err_mask   sticky per-target timeout flags
//   o_cur_idx    index of the target being serviced
module aha_reset_sequencer #(
   parameter  int NUM_TARGETS    = 8,
   parameter  int TIMEOUT_CYCLES = 256,
   parameter  int GAP_CYCLES     = 4,
   localparam int IW = (NUM_TARGETS > 32'sd1) ? $clog2(NUM_TARGETS) : 32'sd1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_seq_start,
   input  logic [NUM_TARGETS-1:0] i_seq_mask,
   input  logic                   i_seq_abort,
   output logic [NUM_TARGETS-1:0] o_rst_req,
   input  logic [NUM_TARGETS-1:0] i_rst_ack,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [NUM_TARGETS-1:0] o_err_mask,
   output logic [IW-1:0]          o_cur_idx
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int GW = (GAP_CYCLES > 32'sd1) ? $clog2(GAP_CYCLES) : 32'sd1;
   localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT_CYCLES - 32'sd1);
   localparam logic [GW-1:0]          GAP_LAST = GW'(GAP_CYCLES - 32'sd1);
   localparam logic [NUM_TARGETS-1:0] ONE_HOT0 = NUM_TARGETS'(1'b1);
   localparam bit                     HAS_GAP  = (GAP_CYCLES > 32'sd0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_REQ_HI = 3'd2,
      S_REQ_LO = 3'd3,
      S_GAP    = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t                 r_state;
   logic [NUM_TARGETS-1:0] r_ack_s1;
   logic [NUM_TARGETS-1:0] r_ack_s2;
   logic [NUM_TARGETS-1:0] r_pend;
   logic                   r_abort_q;
   logic [IW-1:0]          r_cur_idx;
   logic [TW-1:0]          r_tmo_cnt;
   logic [GW-1:0]          r_gap_cnt;
   logic [NUM_TARGETS-1:0] r_rst_req;
   logic [NUM_TARGETS-1:0] r_err;
   logic                   r_busy;
   logic                   r_done;
   logic [IW-1:0]          w_low_idx;
   logic                   w_ack_cur;

   // Two-flop synchronizer for the asynchronous acknowledges.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ack_s1 <= {NUM_TARGETS{1'b0}};
         r_ack_s2 <= {NUM_TARGETS{1'b0}};
      end else begin
         r_ack_s1 <= i_rst_ack;
         r_ack_s2 <= r_ack_s1;
      end
   end

   // Lowest pending target: scanning high-to-low lets the lowest set bit win.
   always_comb begin
      w_low_idx = {IW{1'b0}};
      for (int k = NUM_TARGETS - 32'sd1; k >= 32'sd0; k--) begin
         w_low_idx = r_pend[k] ? IW'(k) : w_low_idx;
      end
   end

   assign w_ack_cur = r_ack_s2[r_cur_idx];

   // Sequencer state machine; every output is a register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_pend    <= {NUM_TARGETS{1'b0}};
         r_abort_q <= 1'b0;
         r_cur_idx <= {IW{1'b0}};
         r_tmo_cnt <= {TW{1'b0}};
         r_gap_cnt <= {GW{1'b0}};
         r_rst_req <= {NUM_TARGETS{1'b0}};
         r_err     <= {NUM_TARGETS{1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         // Abort is only remembered here; SCAN is the one place it is acted on,
         // so an in-flight handshake always runs to completion.
         if ((r_state != S_IDLE) && i_seq_abort) begin
            r_abort_q <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (i_seq_start) begin
                  r_pend    <= i_seq_mask;
                  r_err     <= {NUM_TARGETS{1'b0}};
                  r_abort_q <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if ((r_pend == {NUM_TARGETS{1'b0}}) || r_abort_q) begin
                  r_done  <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_cur_idx         <= w_low_idx;
                  r_pend[w_low_idx] <= 1'b0;
                  r_tmo_cnt         <= {TW{1'b0}};
                  r_rst_req         <= ONE_HOT0 << w_low_idx;
                  r_state           <= S_REQ_HI;
               end
            end
            S_REQ_HI: begin
               // An acknowledge seen on the last allowed cycle still counts as success.
               if (w_ack_cur || (r_tmo_cnt == TMO_LAST)) begin
                  if (!w_ack_cur) begin
                     r_err[r_cur_idx] <= 1'b1;
                  end
                  r_rst_req <= {NUM_TARGETS{1'b0}};
                  r_tmo_cnt <= {TW{1'b0}};
                  r_state   <= S_REQ_LO;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1'b1);
               end
            end
            S_REQ_LO: begin
               if (!w_ack_cur || (r_tmo_cnt == TMO_LAST)) begin
                  if (w_ack_cur) begin
                     r_err[r_cur_idx] <= 1'b1;
                  end
                  r_gap_cnt <= {GW{1'b0}};
                  r_state   <= HAS_GAP ? S_GAP : S_SCAN;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1'b1);
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_SCAN;
               end else begin
                  r_gap_cnt <= r_gap_cnt + GW'(1'b1);
               end
            end
            S_FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_rst_req <= {NUM_TARGETS{1'b0}};
               r_done    <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign o_rst_req  = r_rst_req;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_err_mask = r_err;
   assign o_cur_idx  = r_cur_idx;

endmodule

// File: tb/tb_aha_reset_sequencer.sv
// tb_aha_reset_sequencer
// Purpose: drives aha_reset_sequencer with directed and randomized sequences.
// A behavioural generator model answers the handshake on i_rst_ack.
// A timeline reference model predicts every output, and it is compared with
// the DUT on each falling clock edge.
module tb_aha_reset_sequencer;
   localparam int N  = 8;
   localparam int T  = 16;
   localparam int G  = 4;
   localparam int IW = 3;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [N-1:0]  mask  = '0;
   logic [N-1:0]  ack_pin = '0;
   logic [N-1:0]  req;
   logic [N-1:0]  err;
   logic          busy;
   logic          done;
   logic [IW-1:0] idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   aha_reset_sequencer #(
      .NUM_TARGETS   (N),
      .TIMEOUT_CYCLES(T),
      .GAP_CYCLES    (G)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_seq_start(start),
      .i_seq_mask (mask),
      .i_seq_abort(abort),
      .o_rst_req  (req),
      .i_rst_ack  (ack_pin),
      .o_busy     (busy),
      .o_done     (done),
      .o_err_mask (err),
      .o_cur_idx  (idx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reset generator model ----------------
   // Each generator raises ACK dly[j] falling edges after it sees REQ high and
   // lowers it dly[j] falling edges after REQ drops; stuck masks override.
   int           dly    [N] = '{default: 3};
   int           hi_cnt [N] = '{default: 0};
   int           lo_cnt [N] = '{default: 0};
   logic [N-1:0] gen_ack  = '0;
   logic [N-1:0] stuck_lo = '0;
   logic [N-1:0] stuck_hi = '0;

   always @(negedge clk) begin
      for (int j = 0; j < N; j++) begin
         if (req[j]) begin
            lo_cnt[j] = 0;
            hi_cnt[j]++;
            if (hi_cnt[j] >= dly[j]) gen_ack[j] = 1'b1;
         end else begin
            hi_cnt[j] = 0;
            lo_cnt[j]++;
            if (lo_cnt[j] >= dly[j]) gen_ack[j] = 1'b0;
         end
      end
      ack_pin = (gen_ack & ~stuck_lo) | stuck_hi;
   end

   // ---------------- reference model ----------------
   logic [N-1:0]  m_req = '0;
   logic [N-1:0]  m_err = '0;
   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   logic [IW-1:0] m_idx = '0;
   logic          m_kill = 1'b0;
   logic [N-1:0]  d1 = '0;
   logic [N-1:0]  d2 = '0;
   logic          s_start = 1'b0;
   logic          s_abort = 1'b0;
   logic [N-1:0]  s_mask = '0;

   // Advance one clock; 'a' is the synchronized ACK seen during the cycle that
   // just ended (the pin value two cycles earlier).
   task automatic tick(output logic [N-1:0] a);
      @(posedge clk or posedge rst);
      if (rst) begin
         m_kill = 1'b1;
         a = '0;
      end else begin
         a = d2;
         d2 = d1;
         d1 = ack_pin;
         s_start = start;
         s_mask  = mask;
         s_abort = abort;
      end
   endtask

   task automatic model_run();
      logic [N-1:0] a;
      logic [N-1:0] pend;
      logic         ab;
      int           i;
      int           n;
      forever begin
         m_busy = 1'b0;
         m_req  = '0;
         m_done = 1'b0;
         do begin
            tick(a);
            if (m_kill) return;
         end while (!s_start);
         pend = s_mask;
         m_err = '0;
         ab = 1'b0;
         m_busy = 1'b1;
         forever begin
            tick(a);                       // the scan decision
            if (m_kill) return;
            if (pend == '0 || ab) begin
               m_done = 1'b1;
               break;
            end
            ab |= s_abort;
            i = 0;
            while (!pend[i]) i++;
            pend[i] = 1'b0;
            m_idx = IW'(i);
            m_req = '0;
            m_req[i] = 1'b1;
            n = 0;
            forever begin                  // request phase
               tick(a);
               if (m_kill) return;
               ab |= s_abort;
               if (a[i]) break;
               if (n == T - 1) begin
                  m_err[i] = 1'b1;
                  break;
               end
               n++;
            end
            m_req = '0;
            n = 0;
            forever begin                  // release phase
               tick(a);
               if (m_kill) return;
               ab |= s_abort;
               if (!a[i]) break;
               if (n == T - 1) begin
                  m_err[i] = 1'b1;
                  break;
               end
               n++;
            end
            repeat (G) begin
               tick(a);
               if (m_kill) return;
               ab |= s_abort;
            end
         end
         tick(a);                          // the done cycle
         if (m_kill) return;
      end
   endtask

   always begin
      m_req  = '0;
      m_err  = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_idx  = '0;
      d1     = '0;
      d2     = '0;
      m_kill = 1'b0;
      wait (rst == 1'b0);
      model_run();
   end

   // ---------------- compare / monitor ----------------
   int           done_cnt = 0;
   int           req1_cnt = 0;
   logic [N-1:0] seen = '0;

   always @(negedge clk) begin
      check("rst_req", 32'(req), 32'(m_req));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("err_mask", 32'(err), 32'(m_err));
      check("cur_idx", 32'(idx), 32'(m_idx));
      check("req_onehot", 32'($countones(req) <= 1), 32'd1);
      if (done) done_cnt++;
      if (req[1]) req1_cnt++;
      seen |= req;
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_gen(input int d, input logic [N-1:0] slo, input logic [N-1:0] shi);
      for (int j = 0; j < N; j++) dly[j] = d;
      stuck_lo = slo;
      stuck_hi = shi;
   endtask

   task automatic pulse_start(input logic [N-1:0] m);
      mask  = m;
      start = 1'b1;
      cyc();
      start = 1'b0;
      mask  = N'($urandom);
   endtask

   task automatic wait_done(input string nm, input int budget);
      int d0;
      int k;
      d0 = done_cnt;
      k = 0;
      while (done_cnt == d0 && k < budget) begin
         cyc();
         k++;
      end
      check(nm, 32'(done_cnt > d0), 32'd1);
   endtask

   task automatic wait_req(input string nm, input int bit_i, input int budget);
      int k;
      k = 0;
      while (!req[bit_i] && k < budget) begin
         cyc();
         k++;
      end
      check(nm, 32'(req[bit_i]), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      int d0;
      set_gen(3, '0, '0);
      repeat (3) cyc();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_req", 32'(req), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_idx", 32'(idx), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      rst = 1'b0;
      cyc();

      // Two targets, ACK after 3 cycles.
      seen = '0;
      d0 = done_cnt;
      pulse_start(8'h05);
      check("t1_scan_busy", 32'(busy), 32'd1);
      check("t1_scan_req", 32'(req), 32'd0);
      cyc();
      check("t1_first_req", 32'(req), 32'h01);
      wait_done("t1_done_seen", 300);
      repeat (2) cyc();
      check("t1_seen_req", 32'(seen), 32'h05);
      check("t1_err", 32'(err), 32'h00);
      check("t1_done_once", 32'(done_cnt - d0), 32'd1);

      // Empty mask.
      seen = '0;
      pulse_start(8'h00);
      check("t2_c1_busy", 32'(busy), 32'd1);
      check("t2_c1_done", 32'(done), 32'd0);
      cyc();
      check("t2_c2_done", 32'(done), 32'd1);
      check("t2_c2_busy", 32'(busy), 32'd1);
      cyc();
      check("t2_c3_busy", 32'(busy), 32'd0);
      check("t2_c3_done", 32'(done), 32'd0);
      check("t2_no_req", 32'(seen), 32'h00);

      // ACK[1] stuck low: request phase times out.
      set_gen(3, 8'h02, '0);
      req1_cnt = 0;
      pulse_start(8'h02);
      wait_done("t3_done_seen", 300);
      cyc();
      check("t3_req_hi_cycles", 32'(req1_cnt), 32'd16);
      check("t3_err", 32'(err), 32'h02);

      // Abort while target 3 is being requested.
      set_gen(3, '0, '0);
      seen = '0;
      pulse_start(8'hFF);
      wait_req("t4_reach_t3", 3, 500);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      wait_done("t4_done_seen", 300);
      cyc();
      check("t4_seen_req", 32'(seen), 32'h0F);
      check("t4_err", 32'(err), 32'h00);

      // Reset while target 5 is requested, then a normal run.
      pulse_start(8'hFF);
      wait_req("t5_reach_t5", 5, 800);
      rst = 1'b1;
      #1;
      check("t5_rst_req", 32'(req), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_err", 32'(err), 32'd0);
      check("t5_rst_idx", 32'(idx), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      repeat (2) cyc();
      rst = 1'b0;
      repeat (4) cyc();
      seen = '0;
      pulse_start(8'h20);
      wait_done("t5_done_seen", 300);
      cyc();
      check("t5_seen_req", 32'(seen), 32'h20);
      check("t5_err", 32'(err), 32'h00);

      // Start pulses while busy are ignored.
      set_gen(3, 8'h02, '0);
      seen = '0;
      pulse_start(8'h06);
      repeat (5) begin
         cyc();
         mask  = 8'hF0;
         start = 1'b1;
         cyc();
         start = 1'b0;
      end
      wait_done("t6_done_seen", 300);
      cyc();
      check("t6_seen_req", 32'(seen), 32'h06);
      check("t6_err", 32'(err), 32'h02);

      // Start coincident with the done cycle is ignored.
      set_gen(3, '0, '0);
      pulse_start(8'h00);
      cyc();
      mask  = 8'hFF;
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("t6_fin_start_busy", 32'(busy), 32'd0);
      cyc();
      check("t6_fin_start_busy2", 32'(busy), 32'd0);
      check("t6_fin_start_req", 32'(req), 32'd0);

      // Randomized sequences.
      for (int it = 0; it < 25; it++) begin
         int k;
         int d0r;
         for (int j = 0; j < N; j++) dly[j] = int'($urandom_range(20, 0));
         stuck_lo = N'($urandom & $urandom & $urandom);
         stuck_hi = N'($urandom & $urandom & $urandom) & ~stuck_lo;
         d0r = done_cnt;
         pulse_start(N'($urandom));
         k = 0;
         while (done_cnt == d0r && k < 800) begin
            abort = ($urandom_range(39, 0) == 0);
            if ($urandom_range(9, 0) == 0) begin
               start = 1'b1;
               mask  = N'($urandom);
            end
            cyc();
            start = 1'b0;
            abort = 1'b0;
            k++;
         end
         check("rand_done_seen", 32'(done_cnt > d0r), 32'd1);
         repeat (3) cyc();
      end
      set_gen(3, '0, '0);
      repeat (10) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
